// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pc_src encodings, NOP constant and fetch FSM states
package cpu_pkg;
    localparam logic [1:0]  PC_SEQ  = 2'b00;
    localparam logic [1:0]  PC_IMM  = 2'b01;
    localparam logic [1:0]  PC_JALR = 2'b10;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_TRAP} fetch_state_e;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection for sequential, PC+imm and JALR flow
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [1:0]      i_pc_src,
    input  logic            i_branch,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1_val,
    output logic [XLEN-1:0] o_next_pc,
    output logic [XLEN-1:0] o_pc_plus4
);
    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_jalr;
    assign w_pc_imm   = i_pc + i_imm;
    assign w_jalr     = i_rs1_val + i_imm;
    assign o_pc_plus4 = i_pc + XLEN'(4);
    // conditional branches fall through unless taken; JAL (branch=0) always jumps
    assign o_next_pc  = (i_pc_src == PC_IMM)  ? ((!i_branch || i_branch_taken) ? w_pc_imm : o_pc_plus4) :
                        (i_pc_src == PC_JALR) ? {w_jalr[XLEN-1:1], 1'b0} : o_pc_plus4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing instruction reads and holding the instruction until retire
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            retire,
    input  logic [1:0]      pc_src,
    input  logic            branch,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic            misaligned
);
    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_instr_valid;
    logic            r_req_valid;
    logic            r_misaligned;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_pc_plus4;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc (
        .i_pc           (r_pc),
        .i_pc_src       (pc_src),
        .i_branch       (branch),
        .i_branch_taken (branch_taken),
        .i_imm          (imm),
        .i_rs1_val      (rs1_val),
        .o_next_pc      (w_next_pc),
        .o_pc_plus4     (w_pc_plus4)
    );

    // request valid is registered so it stays low throughout reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= XLEN'(RESET_PC);
            r_instr       <= NOP;
            r_instr_valid <= 1'b0;
            r_req_valid   <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    r_req_valid <= 1'b1;
                    if (r_req_valid && imem_req_ready) begin
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                S_WAIT: if (imem_rsp_valid) begin
                    r_instr       <= imem_rsp_data;
                    r_instr_valid <= 1'b1;
                    r_state       <= S_HOLD;
                end
                S_HOLD: if (retire) begin
                    r_pc          <= w_next_pc;
                    r_instr_valid <= 1'b0;
                    if (|w_next_pc[1:0]) begin
                        r_state      <= S_TRAP;
                        r_misaligned <= 1'b1;
                    end else begin
                        r_state     <= S_REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = r_instr_valid;
    assign instr          = r_instr;
    assign instr_pc       = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign misaligned     = r_misaligned;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch handshake, next-PC selection, trap and reset
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        retire = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic        branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] rs1_val = '0;
    logic        misaligned;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h100), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4),
        .retire         (retire),
        .pc_src         (pc_src),
        .branch         (branch),
        .branch_taken   (branch_taken),
        .imm            (imm),
        .rs1_val        (rs1_val),
        .misaligned     (misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // waits for a request, optionally stalls, completes a 1-cycle response and checks the hold state
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int stall);
        for (int i = 0; i < 20 && !imem_req_valid; i++) @(negedge clk);
        check("req_valid", {31'b0, imem_req_valid}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            check("stall_addr", imem_req_addr, addr);
            check("stall_valid", {31'b0, imem_req_valid}, 32'd1);
            @(negedge clk);
        end
        check("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("instr_valid", {31'b0, instr_valid}, 32'd1);
        check("instr", instr, data);
        check("instr_pc", instr_pc, addr);
        check("pc_plus4", pc_plus4, addr + 32'd4);
    endtask

    task automatic do_retire(input logic [1:0] src, input logic br, input logic tk,
                             input logic [31:0] im, input logic [31:0] rs1);
        pc_src = src; branch = br; branch_taken = tk; imm = im; rs1_val = rs1;
        retire = 1'b1;
        @(negedge clk);
        retire = 1'b0;
        pc_src = 2'b00; branch = 1'b0; branch_taken = 1'b0; imm = '0; rs1_val = '0;
        check("retire_drop", {31'b0, instr_valid}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_addr", imem_req_addr, 32'h100);
        check("rst_instr", instr, 32'h13);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr_pc", instr_pc, 32'h100);
        check("rst_pc_plus4", pc_plus4, 32'h104);
        check("rst_misaligned", {31'b0, misaligned}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", {31'b0, imem_req_valid}, 32'd1);

        fetch(32'h100, 32'h0000_0033, 0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0000;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("hold_ignores_rsp", instr, 32'h0000_0033);
        do_retire(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(32'h104, 32'h0FC0_006F, 3);
        do_retire(2'b01, 1'b0, 1'b0, 32'h0000_00FC, 32'h0);
        fetch(32'h200, 32'h0000_0063, 0);
        do_retire(2'b01, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0);
        fetch(32'h1F8, 32'h0000_0067, 0);
        do_retire(2'b10, 1'b0, 1'b0, 32'h4, 32'h1001);
        fetch(32'h1004, 32'h0000_0067, 0);
        do_retire(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h201);
        fetch(32'h200, 32'h0000_0063, 0);
        do_retire(2'b01, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
        fetch(32'h204, 32'h0000_0013, 0);
        do_retire(2'b11, 1'b0, 1'b0, 32'h40, 32'h0);
        fetch(32'h208, 32'h0000_006F, 0);
        do_retire(2'b01, 1'b0, 1'b1, 32'hFFFF_FDF4, 32'h0);
        fetch(32'hFFFF_FFFC, 32'h0000_0033, 0);
        do_retire(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(32'h0, 32'h0000_006F, 0);
        do_retire(2'b01, 1'b0, 1'b0, 32'h300, 32'h0);
        fetch(32'h300, 32'h1020_006F, 0);
        do_retire(2'b01, 1'b0, 1'b0, 32'h102, 32'h0);
        check("trap_misaligned", {31'b0, misaligned}, 32'd1);
        check("trap_pc", imem_req_addr, 32'h402);
        retire = 1'b1; imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("trap_no_req", {31'b0, imem_req_valid}, 32'd0);
            check("trap_no_instr", {31'b0, instr_valid}, 32'd0);
        end
        retire = 1'b0; imem_req_ready = 1'b0;
        check("trap_pc_hold", instr_pc, 32'h402);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_misaligned", {31'b0, misaligned}, 32'd0);
        check("rst2_req", {31'b0, imem_req_valid}, 32'd1);
        check("rst2_addr", imem_req_addr, 32'h100);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("wait_entered", {31'b0, imem_req_valid}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("midwait_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("midwait_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("midwait_addr", imem_req_addr, 32'h100);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("rst_stale_instr", instr, 32'h13);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", {31'b0, imem_req_valid}, 32'd1);
        check("post_rst_addr", imem_req_addr, 32'h100);
        check("post_rst_instr", instr, 32'h13);
        check("post_rst_iv", {31'b0, instr_valid}, 32'd0);
        fetch(32'h100, 32'h0010_0093, 0);
        do_retire(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        check("final_addr", imem_req_addr, 32'h104);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RV32I processor; sits directly upstream of `control_unit`/`alu_control`. Owns the program counter and issues word reads to instruction memory over a valid/ready handshake. Holds the returned instruction stable for decode until the datapath signals retirement, then computes the next PC from the control unit's `pc_src`/`branch` outputs and the datapath's branch outcome.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `XLEN`, 32: address/data width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out XLEN: word address (byte-addressed, [1:0]=0).
- `imem_rsp_valid` in 1: instruction data valid.
- `imem_rsp_data` in 32: instruction word.
- `instr_valid` out 1: `instr` is valid for decode.
- `instr` out 32: held instruction, feeds `opcode`/`funct3`/`funct7` slicing.
- `instr_pc` out XLEN: PC of `instr`.
- `pc_plus4` out XLEN: `instr_pc + 4`, for JAL/JALR link write.
- `retire` in 1: current instruction completes this cycle.
- `pc_src` in 2: from control unit; 00 sequential, 01 PC+imm (JAL/branch), 10 JALR, 11 reserved.
- `branch` in 1: from control unit.
- `branch_taken` in 1: branch comparison result from datapath.
- `imm` in XLEN: sign-extended immediate.
- `rs1_val` in XLEN: rs1 operand for JALR.
- `misaligned` out 1: sticky instruction-address-misaligned trap.

## Operation
- FSM states: `REQ`, `WAIT`, `HOLD`, `TRAP`. Reset state `REQ`.
- `REQ`: `imem_req_valid`=1, `imem_req_addr`=PC. On `imem_req_valid && imem_req_ready` -> `WAIT`.
- `WAIT`: on `imem_rsp_valid`, capture `imem_rsp_data` into `instr` -> `HOLD`.
- `HOLD`: `instr_valid`=1; `instr`, `instr_pc`, `pc_plus4` stable. On `retire`: PC <= next_pc; if next_pc[1:0]≠0 -> `TRAP`, else -> `REQ`.
- next_pc: `pc_src`=01 with `branch`=0 -> PC+imm; `pc_src`=01 with `branch`=1 -> `branch_taken` ? PC+imm : PC+4; `pc_src`=10 -> (rs1_val+imm) & ~1; 00 or 11 -> PC+4.
- `TRAP`: `misaligned`=1, no requests, `instr_valid`=0; exits only on reset. PC holds offending target.
- All additions modulo 2^XLEN; 0xFFFF_FFFC + 4 = 0x0000_0000.
- `retire` outside `HOLD` ignored. `imem_rsp_valid` outside `WAIT` ignored. `pc_src`/`branch`/`branch_taken`/`imm`/`rs1_val` only sampled in `HOLD` with `retire`.

## Timing
- Reset values: `imem_req_valid`=0 while `rst_n`=0, then 1 in the first cycle after deassertion; `imem_req_addr`=`RESET_PC`; `instr`=32'h0000_0013 (NOP); `instr_valid`=0; `instr_pc`=`RESET_PC`; `pc_plus4`=`RESET_PC`+4; `misaligned`=0.
- Minimum loop: request accepted cycle N, response N+1, `instr_valid` N+2, retire N+2, next request N+3 (3 cycles/instruction).
- Request held with stable address until `imem_req_ready`; any number of stall cycles in `REQ` or `WAIT`.
- `instr_valid` drops the cycle after `retire`.
- Response in the same cycle as request acceptance is a protocol violation; not supported.
- Reset asserted mid-`WAIT`: FSM to `REQ` immediately, in-flight response discarded; memory is reset by the same `rst_n`.

## Structure
- Shared `cpu_pkg`: `pc_src` encodings (`PC_SEQ`, `PC_IMM`, `PC_JALR`), NOP constant 32'h0000_0013, fetch FSM state enum. `control_unit` imports the same `pc_src` constants.
- One sub-module: `next_pc_calc` (combinational next-PC mux and adders); FSM and registers in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0x100, ready=1, 1-cycle response -> request addr 0x100, `instr_valid` two cycles later, `instr_pc`=0x100, `pc_plus4`=0x104.
- Retire ADD (`pc_src`=00) at 0x100 -> next request addr 0x104; hold `imem_req_ready`=0 for 3 cycles -> addr stays 0x104, valid stays 1.
- BEQ at 0x200, imm=-8: `branch_taken`=1 -> 0x1F8; `branch_taken`=0 -> 0x204.
- JALR `rs1_val`=0x1001, imm=4 -> 0x1004; JAL at 0x300, imm=0x102 -> `misaligned`=1, no further requests, PC=0x402.
- `instr_pc`=0xFFFF_FFFC, `pc_src`=00 retire -> request addr 0x0000_0000.
- Assert `rst_n` low in `WAIT`, pulse `imem_rsp_valid` during reset -> all outputs at reset values, first post-reset request to `RESET_PC`, stale data never reaches `instr`.
